alu_cmd_sequencer: RTL and testbench

Parametrised command sequencer feeding the ALU from program ROM. It fetches command words {cin, cmd, op1, op2} from a synchronous ROM and issues each to the ALU over a req/ack handshake. It captures results, counts completed commands and stops at a programmable last address. It replaces the fixed 8-bit, free-running fetch loop in the top level, adding per-command carry-in, run/pause control, end-of-program detection and ack timeout.

---
 rtl/alu_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - fetches {cin, cmd, op1, op2} words from ROM and issues them to the ALU
module alu_cmd_sequencer #(
    parameter int N    = 8,
    parameter int CMDW = 2,
    parameter int AW   = 8,
    parameter int CNTW = 16,
    parameter int TMO  = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enb,
    input  logic [AW-1:0]       i_last_addr,
    output logic [AW-1:0]       o_rom_addr,
    input  logic [CMDW+2*N:0]   i_rom_data,
    output logic                o_alu_req,
    output logic                o_alu_cin,
    output logic [CMDW-1:0]     o_alu_cmd,
    output logic [N-1:0]        o_alu_op1,
    output logic [N-1:0]        o_alu_op2,
    input  logic                i_alu_ack,
    input  logic [2*N-1:0]      i_alu_out,
    output logic [2*N-1:0]      o_result,
    output logic                o_result_valid,
    output logic [CNTW-1:0]     o_cmd_cntr,
    output logic [CNTW-1:0]     o_err_cntr,
    output logic                o_busy,
    output logic                o_done
);
    localparam int W        = 1 + CMDW + 2 * N;
    localparam int TMO_LAST = (TMO > 0) ? TMO - 1 : 0;
    localparam int TW       = (TMO_LAST > 0) ? $clog2(TMO_LAST + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_rom_addr;
    logic              r_alu_req;
    logic              r_alu_cin;
    logic [CMDW-1:0]   r_alu_cmd;
    logic [N-1:0]      r_alu_op1;
    logic [N-1:0]      r_alu_op2;
    logic [2*N-1:0]    r_result;
    logic              r_result_valid;
    logic [CNTW-1:0]   r_cmd_cntr;
    logic [CNTW-1:0]   r_err_cntr;
    logic              r_busy;
    logic              r_done;
    logic [TW-1:0]     r_tmo_cnt;

    logic              w_timeout;
    logic              w_exit;

    // Counter holds the number of WAIT edges already seen, so the TMO-th edge matches TMO-1.
    assign w_timeout = (TMO > 0) && (r_tmo_cnt == TW'(TMO_LAST));
    assign w_exit    = i_alu_ack || w_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_rom_addr     <= '0;
            r_alu_req      <= 1'b0;
            r_alu_cin      <= 1'b0;
            r_alu_cmd      <= '0;
            r_alu_op1      <= '0;
            r_alu_op2      <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_cmd_cntr     <= '0;
            r_err_cntr     <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_tmo_cnt      <= '0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_enb) begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_alu_cin <= i_rom_data[W-1];
                    r_alu_cmd <= i_rom_data[W-2 -: CMDW];
                    r_alu_op1 <= i_rom_data[2*N-1 -: N];
                    r_alu_op2 <= i_rom_data[N-1:0];
                    r_alu_req <= 1'b1;
                    r_tmo_cnt <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_exit) begin
                        r_alu_req <= 1'b0;
                        if (i_alu_ack) begin
                            r_result       <= i_alu_out;
                            r_result_valid <= 1'b1;
                            if (r_cmd_cntr != {CNTW{1'b1}})
                                r_cmd_cntr <= r_cmd_cntr + CNTW'(1);
                        end else if (r_err_cntr != {CNTW{1'b1}}) begin
                            r_err_cntr <= r_err_cntr + CNTW'(1);
                        end
                        if (r_rom_addr == i_last_addr) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_rom_addr <= r_rom_addr + AW'(1);
                            if (i_enb) begin
                                r_state <= S_FETCH;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                S_DONE: begin
                    if (!i_enb) begin
                        r_state    <= S_IDLE;
                        r_rom_addr <= '0;
                        r_done     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rom_addr     = r_rom_addr;
    assign o_alu_req      = r_alu_req;
    assign o_alu_cin      = r_alu_cin;
    assign o_alu_cmd      = r_alu_cmd;
    assign o_alu_op1      = r_alu_op1;
    assign o_alu_op2      = r_alu_op2;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_cmd_cntr     = r_cmd_cntr;
    assign o_err_cntr     = r_err_cntr;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed vector bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

    typedef struct {
        logic        cin;
        logic [1:0]  cmd;
        logic [7:0]  op1;
        logic [7:0]  op2;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [8];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    // Instance A: wide address, 16-bit counters, TMO=16
    logic        enb_a;
    logic [7:0]  last_a, addr_a;
    logic [18:0] rom_data_a;
    logic        req_a, cin_a, ack_a, rv_a, busy_a, done_a;
    logic [1:0]  cmd_a;
    logic [7:0]  op1_a, op2_a;
    logic [15:0] alu_out_a, res_a, cmdc_a, errc_a;
    logic [18:0] rom_a [256];
    int          c_a = 0;
    int          ack_dly_a;

    // Instance B: 2-bit address, 2-bit counters, TMO=4
    logic        enb_b;
    logic [1:0]  last_b, addr_b;
    logic [18:0] rom_data_b;
    logic        req_b, cin_b, ack_b, rv_b, busy_b, done_b;
    logic [1:0]  cmd_b;
    logic [7:0]  op1_b, op2_b;
    logic [15:0] alu_out_b, res_b;
    logic [1:0]  cmdc_b, errc_b;
    logic [18:0] rom_b [4];
    int          c_b = 0;
    logic        blk_b;

    alu_cmd_sequencer #(.N(8), .CMDW(2), .AW(8), .CNTW(16), .TMO(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_enb(enb_a), .i_last_addr(last_a),
        .o_rom_addr(addr_a), .i_rom_data(rom_data_a),
        .o_alu_req(req_a), .o_alu_cin(cin_a), .o_alu_cmd(cmd_a),
        .o_alu_op1(op1_a), .o_alu_op2(op2_a),
        .i_alu_ack(ack_a), .i_alu_out(alu_out_a),
        .o_result(res_a), .o_result_valid(rv_a),
        .o_cmd_cntr(cmdc_a), .o_err_cntr(errc_a),
        .o_busy(busy_a), .o_done(done_a)
    );

    alu_cmd_sequencer #(.N(8), .CMDW(2), .AW(2), .CNTW(2), .TMO(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_enb(enb_b), .i_last_addr(last_b),
        .o_rom_addr(addr_b), .i_rom_data(rom_data_b),
        .o_alu_req(req_b), .o_alu_cin(cin_b), .o_alu_cmd(cmd_b),
        .o_alu_op1(op1_b), .o_alu_op2(op2_b),
        .i_alu_ack(ack_b), .i_alu_out(alu_out_b),
        .o_result(res_b), .o_result_valid(rv_b),
        .o_cmd_cntr(cmdc_b), .o_err_cntr(errc_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    function automatic logic [15:0] alu_f(input logic cin, input logic [1:0] cmd,
                                          input logic [7:0] a, input logic [7:0] b);
        case (cmd)
            2'd0:    return 16'(a) + 16'(b) + 16'(cin);
            2'd1:    return 16'(a) - 16'(b) - 16'(cin);
            2'd2:    return 16'(a) * 16'(b);
            default: return {a ^ b, a & b};
        endcase
    endfunction

    always @(posedge clk) begin
        rom_data_a <= rom_a[addr_a];
        rom_data_b <= rom_b[addr_b];
        c_a        <= req_a ? c_a + 1 : 0;
        c_b        <= req_b ? c_b + 1 : 0;
    end

    assign ack_a     = req_a && (c_a == ack_dly_a - 1);
    assign ack_b     = req_b && (c_b == 0) && !(blk_b && addr_b == 2'd1);
    assign alu_out_a = alu_f(cin_a, cmd_a, op1_a, op2_a);
    assign alu_out_b = alu_f(cin_b, cmd_b, op1_b, op2_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && req_a === 1'b1 && addr_a < 8'd8)
            chk("hold_fields", 32'({cin_a, cmd_a, op1_a, op2_a}),
                32'({vt[addr_a[2:0]].cin, vt[addr_a[2:0]].cmd,
                     vt[addr_a[2:0]].op1, vt[addr_a[2:0]].op2}));
    end

    task automatic wait_rv_a(output int at);
        at = -1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (rv_a === 1'b1) begin
                at = cyc;
                break;
            end
        end
        chk("rv_a_seen", 32'(rv_a), 1);
    endtask

    task automatic wait_rv_b;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (rv_b === 1'b1) break;
        end
        chk("rv_b_seen", 32'(rv_b), 1);
    endtask

    task automatic wait_req_a(input logic [7:0] a);
        for (int t = 0; t < 100; t++) begin
            if (req_a === 1'b1 && addr_a === a) break;
            @(negedge clk);
        end
        chk("req_a_seen", 32'(req_a), 1);
    endtask

    task automatic wait_done_a;
        for (int t = 0; t < 200; t++) begin
            if (done_a === 1'b1) break;
            @(negedge clk);
        end
        chk("done_a_seen", 32'(done_a), 1);
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int at, prev, nreq1;
        logic [15:0] got [$];

        vt[0] = '{1'b0, 2'd0, 8'h12, 8'h34, 16'h0046};
        vt[1] = '{1'b1, 2'd0, 8'hFF, 8'h01, 16'h0101};
        vt[2] = '{1'b0, 2'd2, 8'h0F, 8'h11, 16'h00FF};
        vt[3] = '{1'b0, 2'd3, 8'hF0, 8'h3C, 16'hCC30};
        vt[4] = '{1'b1, 2'd1, 8'h05, 8'h03, 16'h0001};
        vt[5] = '{1'b0, 2'd1, 8'h03, 8'h05, 16'hFFFE};
        vt[6] = '{1'b1, 2'd0, 8'h80, 8'h80, 16'h0101};
        vt[7] = '{1'b0, 2'd2, 8'hFF, 8'hFF, 16'hFE01};
        for (int i = 0; i < 256; i++) rom_a[i] = '0;
        for (int i = 0; i < 8; i++) rom_a[i] = {vt[i].cin, vt[i].cmd, vt[i].op1, vt[i].op2};
        for (int i = 0; i < 4; i++) rom_b[i] = {vt[i+4].cin, vt[i+4].cmd, vt[i+4].op1, vt[i+4].op2};

        rst_n = 1'b0; enb_a = 1'b0; enb_b = 1'b0;
        last_a = 8'd3; last_b = 2'd3; ack_dly_a = 1; blk_b = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_addr", 32'(addr_a), 0);
        chk("rst_req", 32'(req_a), 0);
        chk("rst_fields", 32'({cin_a, cmd_a, op1_a, op2_a}), 0);
        chk("rst_result", 32'({res_a, rv_a}), 0);
        chk("rst_cntrs", {cmdc_a, errc_a}, 0);
        chk("rst_busy_done", 32'({busy_a, done_a}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy_a), 0);

        // four commands, ack one cycle after req
        enb_a = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_rv_a(at);
            chk("t1_result", 32'(res_a), 32'(vt[k].exp));
            chk("t1_cmd_cntr", 32'(cmdc_a), k + 1);
            if (k > 0) chk("t1_spacing", at - prev, 3);
            prev = at;
        end
        chk("t1_rv_pulse_addr", 32'(addr_a), 3);
        @(negedge clk);
        chk("t1_rv_one_cycle", 32'(rv_a), 0);
        chk("t1_done", 32'({done_a, busy_a}), 32'b10);
        chk("t1_end_addr", 32'(addr_a), 3);
        chk("t1_err", 32'(errc_a), 0);
        enb_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_rearm", 32'({done_a, addr_a}), 0);

        // pause during WAIT of address 1 with a 5-cycle ack
        pulse_reset();
        ack_dly_a = 5;
        enb_a = 1'b1;
        wait_req_a(8'd1);
        enb_a = 1'b0;
        wait_rv_a(at);
        chk("t4_result", 32'(res_a), 32'(vt[1].exp));
        chk("t4_pause_addr", 32'(addr_a), 2);
        chk("t4_pause_busy", 32'(busy_a), 0);
        repeat (3) @(negedge clk);
        chk("t4_paused", 32'({req_a, busy_a, addr_a}), 2);
        chk("t4_cmd_cntr", 32'(cmdc_a), 2);
        enb_a = 1'b1;
        wait_req_a(8'd2);
        chk("t4_resume_addr", 32'(addr_a), 2);
        wait_done_a();
        chk("t4_final_cntr", 32'(cmdc_a), 4);
        chk("t4_final_err", 32'(errc_a), 0);

        // asynchronous reset while a request is outstanding
        enb_a = 1'b0;
        repeat (2) @(negedge clk);
        ack_dly_a = 1;
        enb_a = 1'b1;
        wait_req_a(8'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_req_async", 32'(req_a), 0);
        chk("t5_addr", 32'(addr_a), 0);
        chk("t5_fields", 32'({cin_a, cmd_a, op1_a, op2_a}), 0);
        chk("t5_result", 32'({res_a, rv_a}), 0);
        chk("t5_cntrs", {cmdc_a, errc_a}, 0);
        chk("t5_flags", 32'({busy_a, done_a}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wait_req_a(8'd0);
        chk("t5_restart_addr", 32'(addr_a), 0);
        wait_done_a();
        chk("t5_final_cntr", 32'(cmdc_a), 4);

        // timeout on address 1 of instance B
        enb_a = 1'b0;
        pulse_reset();
        blk_b = 1'b1;
        enb_b = 1'b1;
        nreq1 = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (req_b === 1'b1 && addr_b == 2'd1) nreq1++;
            if (rv_b === 1'b1) got.push_back(res_b);
            if (done_b === 1'b1) break;
        end
        chk("t3_done", 32'(done_b), 1);
        chk("t3_req_cycles", nreq1, 4);
        chk("t3_err_cntr", 32'(errc_b), 1);
        chk("t3_cmd_cntr", 32'(cmdc_b), 3);
        chk("t3_n_results", got.size(), 3);
        if (got.size() == 3) begin
            chk("t3_res0", 32'(got[0]), 32'(vt[4].exp));
            chk("t3_res1", 32'(got[1]), 32'(vt[6].exp));
            chk("t3_res2", 32'(got[2]), 32'(vt[7].exp));
        end

        // address wrap past 2^AW-1 and counter saturation
        enb_b = 1'b0;
        blk_b = 1'b0;
        pulse_reset();
        enb_b = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (req_b === 1'b1) break;
            @(negedge clk);
        end
        enb_b = 1'b0;
        wait_rv_b();
        chk("t6_res_a0", 32'(res_b), 32'(vt[4].exp));
        chk("t6_pause", 32'({busy_b, addr_b}), 1);
        @(negedge clk);
        last_b = 2'd0;
        enb_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_rv_b();
            chk("t6_result", 32'(res_b), 32'(vt[4 + ((k + 1) % 4)].exp));
            chk("t6_cmd_cntr", 32'(cmdc_b), (k + 2 > 3) ? 3 : k + 2);
        end
        @(negedge clk);
        chk("t6_done", 32'({done_b, busy_b}), 32'b10);
        chk("t6_addr", 32'(addr_b), 0);
        chk("t6_sat", 32'(cmdc_b), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
